// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: shared types, register indices, class lengths and fetch-pattern helper
// for the relay-computer instruction sequencer.
package seq_pkg;
  typedef enum logic [2:0] {
    AS_NONE = 3'd0,
    AS_PC   = 3'd1,
    AS_INC  = 3'd2,
    AS_M    = 3'd3,
    AS_XY   = 3'd4,
    AS_J    = 3'd5
  } addr_src_t;
  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_M1 = 3'd4;
  localparam logic [2:0] REG_M2 = 3'd5;
  localparam logic [2:0] REG_X  = 3'd6;
  localparam logic [2:0] REG_Y  = 3'd7;
  typedef enum logic [3:0] {
    CL_MOV8,
    CL_SETAB,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_HALT,
    CL_INCXY,
    CL_GOTO,
    CL_NOP
  } op_class_t;
  localparam logic [4:0] LEN_SHORT = 5'd8;
  localparam logic [4:0] LEN_MEM   = 5'd12;
  localparam logic [4:0] LEN_INCXY = 5'd14;
  localparam logic [4:0] LEN_GOTO  = 5'd24;
  // One 4-cycle read-and-advance pass: p is the phase 1..4 within the pass.
  typedef struct packed {
    addr_src_t addr;
    logic      rd;
    logic      ld;
    logic      pc;
  } fetch_t;
  function automatic fetch_t fetch_pat(input logic [4:0] p);
    fetch_pat = '{addr: (p <= 5'd2) ? AS_PC : AS_INC, rd: p <= 5'd2, ld: p == 5'd2, pc: p == 5'd4};
  endfunction
  function automatic logic [7:0] reg_onehot(input logic [2:0] r);
    return 8'd1 << r;
  endfunction
endpackage

// File: rtl/inst_class_decoder.sv
// inst_class_decoder: maps the latched instruction byte to its opcode class
// and total cycle length.
module inst_class_decoder
  import seq_pkg::*;
(
  input  logic [7:0] i_inst,
  output op_class_t  o_class,
  output logic [4:0] o_len
);
  always_comb begin
    o_class = (i_inst[7:6] == 2'b00)                ? CL_MOV8  :
              (i_inst[7:6] == 2'b01)                ? CL_SETAB :
              (i_inst[7:6] == 2'b11 && !i_inst[0])  ? CL_GOTO  :
              (i_inst[7:4] == 4'b1000)              ? CL_ALU   :
              (i_inst[7:3] == 5'b10010)             ? CL_LOAD  :
              (i_inst[7:3] == 5'b10011)             ? CL_STORE :
              (i_inst == 8'hAE)                     ? CL_HALT  :
              (i_inst == 8'hB0)                     ? CL_INCXY : CL_NOP;
    o_len = (o_class == CL_GOTO)                            ? LEN_GOTO  :
            (o_class == CL_INCXY)                           ? LEN_INCXY :
            (o_class == CL_LOAD || o_class == CL_STORE)     ? LEN_MEM   : LEN_SHORT;
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: cycle-counting control FSM that issues every bus-select
// and load strobe of the relay computer; outputs decode purely from the counter.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int FETCH_CYCLES = 4,
  parameter int MAX_CYCLE    = 24
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_run,
  input  logic       i_step,
  input  logic [7:0] i_inst,
  input  logic       i_zero,
  input  logic       i_carry,
  input  logic       i_sign,
  output logic [4:0] o_cycle,
  output logic       o_halted,
  output logic       o_illegal,
  output logic [2:0] o_addr_src,
  output logic [2:0] o_data_src,
  output logic       o_data_src_en,
  output logic [7:0] o_data_ld,
  output logic       o_alu_drive,
  output logic [2:0] o_alu_fn,
  output logic       o_imm_drive,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_ld_inst,
  output logic       o_ld_inc,
  output logic       o_ld_pc,
  output logic       o_ld_j1,
  output logic       o_ld_j2,
  output logic       o_ld_xy,
  output logic       o_ld_ccr
);
  localparam logic [4:0] FETCH_C = 5'(FETCH_CYCLES);
  localparam logic [4:0] MAX_C   = 5'(MAX_CYCLE);
  logic [4:0] r_cyc, w_cyc_nxt, w_len, w_e, w_p;
  logic       r_step, w_step_nxt;
  logic       w_active, w_fetch, w_exec, w_j1, w_j2, w_taken, w_end, w_cont;
  op_class_t  w_class;
  addr_src_t  w_addr;
  fetch_t     w_f;
  inst_class_decoder u_dec (
    .i_inst  (i_inst),
    .o_class (w_class),
    .o_len   (w_len)
  );
  assign w_active = (r_cyc != 5'd0) && (r_cyc <= MAX_C);
  assign w_fetch  = w_active && (r_cyc <= FETCH_C);
  assign w_exec   = w_active && (r_cyc > FETCH_C);
  assign w_e      = r_cyc - FETCH_C;
  assign w_j1     = w_exec && (w_class == CL_GOTO) && (w_e <= 5'd4);
  assign w_j2     = w_exec && (w_class == CL_GOTO) && (w_e >= 5'd5) && (w_e <= 5'd8);
  assign w_p      = w_fetch ? r_cyc : w_j2 ? w_e - 5'd4 : w_e;
  assign w_f      = fetch_pat(w_p);
  // No condition bits selected means an unconditional jump.
  assign w_taken  = (i_inst[4] & i_sign) | (i_inst[3] & i_carry) | (i_inst[2] & i_zero) |
                    (i_inst[1] & ~i_zero) | (i_inst[4:1] == 4'd0);
  assign w_end    = (r_cyc > MAX_C) || (r_cyc >= w_len);
  assign w_cont   = (r_cyc <= MAX_C) && i_run && !r_step && (w_class != CL_HALT);
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cyc  <= 5'd0;
      r_step <= 1'b0;
    end else begin
      r_cyc  <= w_cyc_nxt;
      r_step <= w_step_nxt;
    end
  end
  always_comb begin
    w_cyc_nxt  = (r_cyc == 5'd0) ? {4'd0, i_run | i_step} : w_end ? {4'd0, w_cont} : r_cyc + 5'd1;
    w_step_nxt = (r_cyc == 5'd0) ? i_step : w_end ? 1'b0 : r_step;
    w_addr        = AS_NONE;
    o_illegal     = 1'b0;
    o_data_src    = 3'd0;
    o_data_src_en = 1'b0;
    o_data_ld     = 8'd0;
    o_alu_drive   = 1'b0;
    o_alu_fn      = 3'd0;
    o_imm_drive   = 1'b0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_ld_inst     = 1'b0;
    o_ld_inc      = 1'b0;
    o_ld_pc       = 1'b0;
    o_ld_j1       = 1'b0;
    o_ld_j2       = 1'b0;
    o_ld_xy       = 1'b0;
    o_ld_ccr      = 1'b0;
    if (w_fetch || w_j1 || w_j2) begin
      w_addr    = w_f.addr;
      o_mem_rd  = w_f.rd;
      o_ld_inc  = w_f.ld;
      o_ld_pc   = w_f.pc;
      o_ld_inst = w_fetch && w_f.ld;
      o_ld_j1   = w_j1 && w_f.ld;
      o_ld_j2   = w_j2 && w_f.ld;
    end
    if (w_exec) begin
      case (w_class)
        CL_MOV8: if (w_e <= 5'd2) begin
          o_data_src    = i_inst[2:0];
          o_data_src_en = 1'b1;
          o_data_ld     = (w_e == 5'd2) ? reg_onehot(i_inst[5:3]) : 8'd0;
        end
        CL_SETAB: if (w_e <= 5'd2) begin
          o_imm_drive = 1'b1;
          o_data_ld   = (w_e == 5'd2) ? reg_onehot(i_inst[5] ? REG_B : REG_A) : 8'd0;
        end
        CL_ALU: if (w_e <= 5'd2) begin
          o_alu_drive = 1'b1;
          o_alu_fn    = i_inst[2:0];
          o_data_ld   = (w_e == 5'd2) ? reg_onehot(i_inst[3] ? REG_D : REG_A) : 8'd0;
          o_ld_ccr    = (w_e == 5'd2);
        end
        CL_LOAD: if (w_e <= 5'd4) begin
          w_addr    = AS_M;
          o_mem_rd  = 1'b1;
          o_data_ld = (w_e == 5'd4) ? reg_onehot({1'b0, i_inst[1:0]}) : 8'd0;
        end
        CL_STORE: if (w_e <= 5'd4) begin
          w_addr        = AS_M;
          o_data_src    = {1'b0, i_inst[1:0]};
          o_data_src_en = 1'b1;
          o_mem_wr      = (w_e == 5'd2) || (w_e == 5'd3);
        end
        CL_INCXY: if (w_e <= 5'd8) begin
          w_addr   = (w_e <= 5'd4) ? AS_XY : AS_INC;
          o_ld_inc = (w_e == 5'd2);
          o_ld_xy  = (w_e == 5'd8);
        end
        CL_GOTO: if (w_e >= 5'd9 && w_e <= 5'd12 && i_inst[5]) begin
          w_addr  = AS_PC;
          o_ld_xy = (w_e == 5'd12);
        end else if (w_e >= 5'd13 && w_e <= 5'd16 && w_taken) begin
          w_addr  = AS_J;
          o_ld_pc = (w_e == 5'd16);
        end
        CL_NOP: o_illegal = (w_e == 5'd1);
        default: ;
      endcase
    end
  end
  assign o_addr_src = w_addr;
  assign o_cycle    = r_cyc;
  assign o_halted   = (r_cyc == 5'd0);
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed checks of the sequencer's per-cycle strobes,
// class lengths, run/step control and asynchronous reset.
module tb_instruction_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, run, step, zero, carry, sign;
  logic [7:0] inst;
  logic [4:0] o_cycle;
  logic       o_halted, o_illegal, o_data_src_en, o_alu_drive, o_imm_drive, o_mem_rd, o_mem_wr;
  logic [2:0] o_addr_src, o_data_src, o_alu_fn;
  logic [7:0] o_data_ld;
  logic       o_ld_inst, o_ld_inc, o_ld_pc, o_ld_j1, o_ld_j2, o_ld_xy, o_ld_ccr;
  logic [36:0] all_out;
  int checks = 0;
  int failures = 0;
  int len;
  logic [31:0] m_rd, m_wr, m_inst, m_inc, m_pc, m_j1, m_j2, m_xy, m_ccr, m_ill;
  logic [31:0] m_en, m_alu, m_imm, m_apc, m_am, m_aj, m_axy, m_conf;
  logic [2:0] ds [32];
  logic [2:0] fn [32];
  logic [7:0] dl [32];
  always #5 clk = ~clk;
  instruction_sequencer dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_run(run), .i_step(step), .i_inst(inst),
    .i_zero(zero), .i_carry(carry), .i_sign(sign),
    .o_cycle(o_cycle), .o_halted(o_halted), .o_illegal(o_illegal), .o_addr_src(o_addr_src),
    .o_data_src(o_data_src), .o_data_src_en(o_data_src_en), .o_data_ld(o_data_ld),
    .o_alu_drive(o_alu_drive), .o_alu_fn(o_alu_fn), .o_imm_drive(o_imm_drive),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_ld_inst(o_ld_inst), .o_ld_inc(o_ld_inc),
    .o_ld_pc(o_ld_pc), .o_ld_j1(o_ld_j1), .o_ld_j2(o_ld_j2), .o_ld_xy(o_ld_xy), .o_ld_ccr(o_ld_ccr)
  );
  assign all_out = {o_addr_src, o_data_src, o_data_src_en, o_data_ld, o_alu_drive, o_alu_fn,
                    o_imm_drive, o_mem_rd, o_mem_wr, o_ld_inst, o_ld_inc, o_ld_pc, o_ld_j1,
                    o_ld_j2, o_ld_xy, o_ld_ccr, o_illegal};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Records one instruction, one sample per negedge, until the counter returns to 0 or wraps.
  task automatic trace();
    int last;
    last = 0;
    len = 0;
    {m_rd, m_wr, m_inst, m_inc, m_pc, m_j1, m_j2, m_xy, m_ccr, m_ill} = '0;
    {m_en, m_alu, m_imm, m_apc, m_am, m_aj, m_axy, m_conf} = '0;
    for (int i = 0; i < 32; i++) begin
      ds[i] = '0;
      fn[i] = '0;
      dl[i] = '0;
    end
    for (int k = 0; k < 30; k++) begin
      int c;
      c = int'(o_cycle);
      if (c == 0 || c <= last) break;
      last = c;
      len = c;
      m_rd   |= 32'(o_mem_rd) << c;
      m_wr   |= 32'(o_mem_wr) << c;
      m_inst |= 32'(o_ld_inst) << c;
      m_inc  |= 32'(o_ld_inc) << c;
      m_pc   |= 32'(o_ld_pc) << c;
      m_j1   |= 32'(o_ld_j1) << c;
      m_j2   |= 32'(o_ld_j2) << c;
      m_xy   |= 32'(o_ld_xy) << c;
      m_ccr  |= 32'(o_ld_ccr) << c;
      m_ill  |= 32'(o_illegal) << c;
      m_en   |= 32'(o_data_src_en) << c;
      m_alu  |= 32'(o_alu_drive) << c;
      m_imm  |= 32'(o_imm_drive) << c;
      m_apc  |= 32'(o_addr_src == 3'd1) << c;
      m_am   |= 32'(o_addr_src == 3'd3) << c;
      m_aj   |= 32'(o_addr_src == 3'd5) << c;
      m_axy  |= 32'(o_addr_src == 3'd4) << c;
      m_conf |= 32'((o_mem_rd & o_mem_wr) ||
                    (int'(o_data_src_en) + int'(o_alu_drive) + int'(o_imm_drive) > 1)) << c;
      ds[c] = o_data_src;
      fn[c] = o_alu_fn;
      dl[c] = o_data_ld;
      @(negedge clk);
    end
  endtask
  task automatic step_instr(input logic [7:0] op);
    @(negedge clk);
    inst = op;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    trace();
  endtask
  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; inst = 8'h00; zero = 1'b0; carry = 1'b0; sign = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cycle", 64'(o_cycle), 0);
    chk("rst_halted", 64'(o_halted), 1);
    chk("rst_outputs", 64'(all_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stays", 64'(o_cycle), 0);
    step_instr(8'h0B);
    chk("mov_len", 64'(len), 8);
    chk("mov_rd", 64'(m_rd), 32'h6);
    chk("mov_ld_inst", 64'(m_inst), 32'h4);
    chk("mov_ld_pc", 64'(m_pc), 32'h10);
    chk("mov_en", 64'(m_en), 32'h60);
    chk("mov_src5", 64'(ds[5]), 3);
    chk("mov_src6", 64'(ds[6]), 3);
    chk("mov_ld5", 64'(dl[5]), 0);
    chk("mov_ld6", 64'(dl[6]), 8'h02);
    chk("mov_idle", 64'(o_halted), 1);
    @(negedge clk);
    chk("mov_idle_hold", 64'(o_cycle), 0);
    inst = 8'h84;
    run = 1'b1;
    @(negedge clk);
    trace();
    chk("alu_len", 64'(len), 8);
    chk("alu_drive", 64'(m_alu), 32'h60);
    chk("alu_fn6", 64'(fn[6]), 4);
    chk("alu_ld6", 64'(dl[6]), 8'h01);
    chk("alu_ccr", 64'(m_ccr), 32'h40);
    chk("alu_run_cont", 64'(o_cycle), 1);
    inst = 8'hAE;
    trace();
    chk("halt_len", 64'(len), 8);
    chk("halt_quiet", 64'(m_en | m_alu | m_imm | m_wr | m_ccr), 0);
    chk("halt_rd", 64'(m_rd), 32'h6);
    chk("halt_halted", 64'(o_halted), 1);
    run = 1'b0;
    zero = 1'b1;
    step_instr(8'hC4);
    chk("goto_t_len", 64'(len), 24);
    chk("goto_t_j1", 64'(m_j1), 32'h40);
    chk("goto_t_j2", 64'(m_j2), 32'h400);
    chk("goto_t_pc", 64'(m_pc), 32'h101110);
    chk("goto_t_aj", 64'(m_aj), 32'h1E0000);
    chk("goto_t_rd", 64'(m_rd), 32'h666);
    chk("goto_t_xy", 64'(m_xy), 0);
    zero = 1'b0;
    step_instr(8'hC4);
    chk("goto_n_len", 64'(len), 24);
    chk("goto_n_pc", 64'(m_pc), 32'h1110);
    chk("goto_n_aj", 64'(m_aj), 0);
    step_instr(8'hE0);
    chk("goto_d_xy", 64'(m_xy), 32'h10000);
    chk("goto_d_apc", 64'(m_apc), 32'h1E666);
    chk("goto_d_aj", 64'(m_aj), 32'h1E0000);
    step_instr(8'h9A);
    chk("st_len", 64'(len), 12);
    chk("st_am", 64'(m_am), 32'h1E0);
    chk("st_src5", 64'(ds[5]), 2);
    chk("st_en", 64'(m_en), 32'h1E0);
    chk("st_wr", 64'(m_wr), 32'hC0);
    chk("st_rd", 64'(m_rd), 32'h6);
    step_instr(8'h91);
    chk("ld_len", 64'(len), 12);
    chk("ld_rd", 64'(m_rd), 32'h1E6);
    chk("ld_dl8", 64'(dl[8]), 8'h02);
    step_instr(8'h65);
    chk("set_imm", 64'(m_imm), 32'h60);
    chk("set_dl6", 64'(dl[6]), 8'h02);
    step_instr(8'hB0);
    chk("incxy_len", 64'(len), 14);
    chk("incxy_axy", 64'(m_axy), 32'h1E0);
    chk("incxy_inc", 64'(m_inc), 32'h44);
    chk("incxy_xy", 64'(m_xy), 32'h1000);
    step_instr(8'hBF);
    chk("nop_len", 64'(len), 8);
    chk("nop_ill", 64'(m_ill), 32'h20);
    @(negedge clk);
    inst = 8'hC4;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (o_cycle == 5'd15) break;
      @(negedge clk);
    end
    chk("arst_at15", 64'(o_cycle), 15);
    rst_n = 1'b0;
    #1;
    chk("arst_cycle", 64'(o_cycle), 0);
    chk("arst_outputs", 64'(all_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle", 64'(o_cycle), 0);
    inst = 8'h0B;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_at3", 64'(o_cycle), 3);
    run = 1'b0;
    trace();
    chk("stop_len", 64'(len), 8);
    chk("stop_idle", 64'(o_cycle), 0);
    @(negedge clk);
    chk("stop_hold", 64'(o_cycle), 0);
    chk("no_conflict", 64'(m_conf), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Central control FSM for the relay computer.
- Steps the machine through the fixed per-class clock-cycle sequences (8/12/14/24) and issues every bus-select and register-load strobe to the register unit, program-control unit, ALU and memory.
- Decodes the latched instruction byte and condition codes, and handles run/stop/single-step control.

Parameters:
- FETCH_CYCLES, 4, cycles 1..FETCH_CYCLES form the common fetch/increment phase.
- MAX_CYCLE, 24, longest instruction length; sets the cycle counter range.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; when 1 in IDLE, start fetch next cycle.
- step  in  1  single-cycle pulse; in IDLE, execute exactly one instruction.
- inst  in  8  instruction register contents (valid from cycle 3).
- zero, carry, sign  in  1 each  condition-code register bits.
- cycle  out  5  current cycle, 0=IDLE, 1..24 active.
- halted  out  1  1 in IDLE.
- illegal  out  1  pulses in cycle 5 of an undefined opcode.
- addr_src  out  3  address-bus driver: NONE/PC/INC/M/XY/J.
- data_src  out  3  register driving data bus (A,B,C,D,M1,M2,X,Y).
- data_src_en  out  1  enable for data_src.
- data_ld  out  8  one-hot load strobes A,B,C,D,M1,M2,X,Y.
- alu_drive, alu_fn  out  1, 3  ALU drives data bus, function = inst[2:0].
- imm_drive  out  1  sign-extended inst[4:0] drives data bus.
- mem_rd, mem_wr  out  1 each  memory strobes.
- ld_inst, ld_inc, ld_pc, ld_j1, ld_j2, ld_xy, ld_ccr  out  1 each  load strobes.

Behaviour:
- State: cycle counter cyc_q (5 b). All outputs decode combinationally from cyc_q, inst and the flags; outputs are valid for the whole cycle in which cyc_q holds the value.
- Reset (async, low): cyc_q=0, halted=1, all strobes 0, addr_src=NONE, data_src_en=0.
- IDLE (0): on run=1 or step=1 -> 1. step sets step_q, which is cleared on the return to IDLE.
- Fetch, all classes:
  - C1: addr_src=PC, mem_rd.
  - C2: addr_src=PC, mem_rd, ld_inst, ld_inc.
  - C3: addr_src=INC.
  - C4: addr_src=INC, ld_pc.
- Classes and lengths, decoded from inst:
  - 00dddsss MOV8, 8 cycles: C5-C6 data_src=sss, data_src_en; C6 data_ld[ddd].
  - 01rvvvvv SETAB, 8 cycles: C5-C6 imm_drive; C6 load A (r=0) or B (r=1).
  - 1000rfff ALU, 8 cycles: C5-C6 alu_drive, alu_fn=fff; C6 load A (r=0) or D (r=1), ld_ccr.
  - 10010xrr LOAD, 12 cycles: C5-C8 addr_src=M, mem_rd; C8 data_ld[rr] (A..D).
  - 10011xrr STORE, 12 cycles: C5-C8 addr_src=M, data_src=rr, data_src_en; C6-C7 mem_wr.
  - 10101110 HALT, 8 cycles: no execute strobes; forces IDLE after C8.
  - 10110000 INCXY, 14 cycles: C5-C8 addr_src=XY, ld_inc on C6; C9-C12 addr_src=INC, ld_xy on C12; C13-C14 quiet.
  - 11dsczn0 GOTO, 24 cycles:
    - C5-C8 repeat the fetch pattern with ld_j1.
    - C9-C12 repeat the fetch pattern with ld_j2.
    - C17-C20: if taken, addr_src=J, ld_pc on C20.
    - taken = (s&sign)|(c&carry)|(z&zero)|(n&~zero), or all four flag bits 0 (unconditional).
    - d=1: C13-C16 addr_src=PC, ld_xy on C16 (save return address).
  - Any other opcode: 8-cycle NOP, illegal=1 in C5.
- End of instruction (cyc_q = class length):
  - go to 1 if run=1, step_q=0 and not HALT;
  - otherwise go to 0 and clear step_q.
- mem_rd and mem_wr are never asserted in the same cycle; at most one of data_src_en, alu_drive, imm_drive is 1 in any cycle.
- run deasserted mid-instruction: the current instruction completes and the machine returns to IDLE.
- Async reset mid-instruction aborts immediately to IDLE; no strobe glitches beyond the reset edge.
- cyc_q never exceeds MAX_CYCLE; an out-of-range value forces IDLE.

Decomposition:
- Shared package seq_pkg:
  - addr_src_t enum;
  - register index constants REG_A..REG_Y;
  - opcode class enum;
  - class length constants 8/12/14/24.
- One sub-module, inst_class_decoder: combinational; inst -> class and length.
- Cycle counter and strobe decode stay in instruction_sequencer.

Test Plan:
- Reset with run=0 -> cycle=0, halted=1, all strobes 0; release, pulse step with inst=8'h0B (MOV8 B<-D... dst=001, src=011) -> C1/C2 mem_rd, C2 ld_inst+ld_inc, C4 ld_pc, C6 data_src=3 and data_ld=8'b0000_0010, back to IDLE at cycle 9.
- run=1, inst=8'h84 (ALU A, fff=100) followed by inst=8'hAE (HALT) -> C6 alu_drive, alu_fn=4, data_ld[A], ld_ccr; HALT runs 8 cycles, then halted=1 with run still 1.
- GOTO inst=8'hC4 (z set) with zero=1 -> ld_j1 at C6, ld_j2 at C10, addr_src=J plus ld_pc at C20, length 24; same test with zero=0 -> no ld_pc in C17-C20.
- STORE inst=8'h9A (rr=2, C) -> addr_src=M C5-C8, data_src=2, mem_wr C6-C7, mem_rd never 1 during C5-C12, length 12.
- INCXY 8'hB0 -> length 14, ld_xy at C12; undefined 8'hBF -> illegal pulse at C5, length 8.
- Drive reset low at cycle 15 of a GOTO -> cycle=0 and all strobes 0 immediately; deassert run at C3 of a MOV8 -> completes C8, then IDLE.
